// File: rtl/player_sprite_arbiter.sv
// Two-player sprite arbiter: hit-tests both chefs against frame-latched positions, issues the ROM address and returns palette index + owner.
// Optional CHOP_ANIM_EN build adds a vsync-driven two-phase chop animation.
module player_sprite_arbiter #(
   parameter int WIDTH = 32,
   parameter int HEIGHT = 32,
   parameter int ANIM_FRAMES = 8,
   localparam int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
   input  logic              pixel_clk_in,
   input  logic              rst_n_in,
   input  logic [10:0]       hcount_in,
   input  logic [9:0]        vcount_in,
   input  logic              vsync_in,
   input  logic [10:0]       p1_x_in,
   input  logic [10:0]       p2_x_in,
   input  logic [9:0]        p1_y_in,
   input  logic [9:0]        p2_y_in,
   input  logic [1:0]        p1_dir_in,
   input  logic [1:0]        p2_dir_in,
   input  logic [3:0]        p1_state_in,
   input  logic [3:0]        p2_state_in,
   output logic [5:0]        sprite_sel_out,
   output logic [ADDR_W-1:0] pix_addr_out,
   input  logic [7:0]        rom_data_in,
   output logic [7:0]        pal_index_out,
   output logic              pal_valid_out,
   output logic [1:0]        owner_out
);

   logic        vsync_q;
   logic        vsync_rise;
   logic [10:0] s_p1_x, s_p2_x;
   logic [9:0]  s_p1_y, s_p2_y;
   logic [1:0]  s_p1_dir, s_p2_dir;
   logic [3:0]  s_p1_state, s_p2_state;
   logic        chop_phase;

   function automatic logic [3:0] map_state(input logic [3:0] st, input logic phase);
      logic [3:0] m;
      case (st)
         4'd0, 4'd2, 4'd3, 4'd4:  m = st;
         4'd1:                    m = phase ? 4'd0 : 4'd1;
         4'd5, 4'd6:              m = 4'd5;
         4'd7, 4'd8, 4'd9, 4'd10: m = st - 4'd1;
         default:                 m = 4'd0;
      endcase
      return m;
   endfunction

   assign vsync_rise = vsync_in && !vsync_q;

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         vsync_q    <= 1'b0;
         s_p1_x     <= '0;
         s_p2_x     <= '0;
         s_p1_y     <= '0;
         s_p2_y     <= '0;
         s_p1_dir   <= '0;
         s_p2_dir   <= '0;
         s_p1_state <= '0;
         s_p2_state <= '0;
      end else begin
         vsync_q <= vsync_in;
         if (vsync_rise) begin
            s_p1_x     <= p1_x_in;
            s_p2_x     <= p2_x_in;
            s_p1_y     <= p1_y_in;
            s_p2_y     <= p2_y_in;
            s_p1_dir   <= p1_dir_in;
            s_p2_dir   <= p2_dir_in;
            s_p1_state <= p1_state_in;
            s_p2_state <= p2_state_in;
         end
      end
   end

`ifdef CHOP_ANIM_EN
   localparam int CNT_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
   logic [CNT_W-1:0] frame_cnt;

   // Phase flips once per ANIM_FRAMES latched frames.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         frame_cnt  <= '0;
         chop_phase <= 1'b0;
      end else if (vsync_rise) begin
         if (frame_cnt == CNT_W'(ANIM_FRAMES - 1)) begin
            frame_cnt  <= '0;
            chop_phase <= !chop_phase;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end
`else
   assign chop_phase = 1'b0;
`endif

   // End coordinates carry one extra bit so players at the screen edge never wrap.
   logic [11:0] p1_x_end, p2_x_end;
   logic [10:0] p1_y_end, p2_y_end;
   logic        p1_hit, p2_hit, p1_wins, any_hit;
   logic [10:0] win_x, dx;
   logic [9:0]  win_y, dy;
   logic [1:0]  win_dir;
   logic [3:0]  win_state;
   logic [5:0]  sel_c;
   logic [ADDR_W-1:0] addr_c;

   assign p1_x_end = {1'b0, s_p1_x} + 12'(WIDTH);
   assign p2_x_end = {1'b0, s_p2_x} + 12'(WIDTH);
   assign p1_y_end = {1'b0, s_p1_y} + 11'(HEIGHT);
   assign p2_y_end = {1'b0, s_p2_y} + 11'(HEIGHT);

   assign p1_hit = (hcount_in >= s_p1_x) && ({1'b0, hcount_in} < p1_x_end) &&
                   (vcount_in >= s_p1_y) && ({1'b0, vcount_in} < p1_y_end);
   assign p2_hit = (hcount_in >= s_p2_x) && ({1'b0, hcount_in} < p2_x_end) &&
                   (vcount_in >= s_p2_y) && ({1'b0, vcount_in} < p2_y_end);
   // Lower on screen wins an overlap; equal rows favour P1.
   assign p1_wins = p1_hit && (!p2_hit || (s_p1_y >= s_p2_y));
   assign any_hit = p1_hit || p2_hit;

   assign win_x     = p1_wins ? s_p1_x     : s_p2_x;
   assign win_y     = p1_wins ? s_p1_y     : s_p2_y;
   assign win_dir   = p1_wins ? s_p1_dir   : s_p2_dir;
   assign win_state = p1_wins ? s_p1_state : s_p2_state;
   assign dx        = hcount_in - win_x;
   assign dy        = vcount_in - win_y;
   assign addr_c    = ADDR_W'(32'(dy) * 32'(WIDTH) + 32'(dx));
   assign sel_c     = {map_state(win_state, chop_phase), win_dir};

   logic [1:0] owner_p1;
   logic       vld_p1;

   // Stage 1: ROM address, sprite select and owner of the winning player.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sprite_sel_out <= '0;
         pix_addr_out   <= '0;
         owner_p1       <= 2'b00;
         vld_p1         <= 1'b0;
      end else if (any_hit) begin
         sprite_sel_out <= sel_c;
         pix_addr_out   <= addr_c;
         owner_p1       <= p1_wins ? 2'b01 : 2'b10;
         vld_p1         <= 1'b1;
      end else begin
         sprite_sel_out <= '0;
         pix_addr_out   <= '0;
         owner_p1       <= 2'b00;
         vld_p1         <= 1'b0;
      end
   end

   logic vld_p2_c;
   assign vld_p2_c = vld_p1 && (rom_data_in != 8'd0);

   // Stage 2: palette index from ROM; index 0 is transparent.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pal_index_out <= '0;
         pal_valid_out <= 1'b0;
         owner_out     <= 2'b00;
      end else begin
         pal_index_out <= vld_p2_c ? rom_data_in : 8'd0;
         pal_valid_out <= vld_p2_c;
         owner_out     <= owner_p1;
      end
   end

endmodule

// File: tb/tb_player_sprite_arbiter.sv
// Bench for player_sprite_arbiter: directed pixel vectors checked every cycle against a frame-level model.
module tb_player_sprite_arbiter;
   localparam int WIDTH = 32;
   localparam int HEIGHT = 32;
   localparam int ANIM_FRAMES = 2;
   localparam int ADDR_W = $clog2(WIDTH*HEIGHT);

   logic              clk;
   logic              rst_n;
   logic [10:0]       hcount;
   logic [9:0]        vcount;
   logic              vsync;
   logic [10:0]       p1_x, p2_x;
   logic [9:0]        p1_y, p2_y;
   logic [1:0]        p1_dir, p2_dir;
   logic [3:0]        p1_state, p2_state;
   logic [5:0]        sprite_sel;
   logic [ADDR_W-1:0] pix_addr;
   logic [7:0]        rom_data;
   logic [7:0]        pal_index;
   logic              pal_valid;
   logic [1:0]        owner;

   player_sprite_arbiter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .ANIM_FRAMES(ANIM_FRAMES)) dut (
      .pixel_clk_in(clk), .rst_n_in(rst_n), .hcount_in(hcount), .vcount_in(vcount),
      .vsync_in(vsync), .p1_x_in(p1_x), .p2_x_in(p2_x), .p1_y_in(p1_y), .p2_y_in(p2_y),
      .p1_dir_in(p1_dir), .p2_dir_in(p2_dir), .p1_state_in(p1_state), .p2_state_in(p2_state),
      .sprite_sel_out(sprite_sel), .pix_addr_out(pix_addr), .rom_data_in(rom_data),
      .pal_index_out(pal_index), .pal_valid_out(pal_valid), .owner_out(owner));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Frame-level model: latched players, priority rule, state lookup table.
   typedef struct {
      int sel;
      int addr;
      int owner;
      bit hit;
   } exp_t;

   int   map_tbl [16] = '{0, 1, 2, 3, 4, 5, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0};
   int   m_x [2];
   int   m_y [2];
   int   m_dir [2];
   int   m_st [2];
   bit   m_vs_prev;
   int   m_cnt;
   bit   m_phase;
   exp_t m_e1;
   int   m_o2, m_v2, m_p2;

   function automatic exp_t model_pix(int h, int v);
      exp_t e;
      bit   hit [2];
      int   w;
      int   mapped;
      for (int i = 0; i < 2; i++)
         hit[i] = (h >= m_x[i]) && (h < m_x[i] + WIDTH) && (v >= m_y[i]) && (v < m_y[i] + HEIGHT);
      if (hit[0] && hit[1]) w = (m_y[1] > m_y[0]) ? 1 : 0;
      else if (hit[0])      w = 0;
      else if (hit[1])      w = 1;
      else                  w = -1;
      e = '{0, 0, 0, 1'b0};
      if (w >= 0) begin
         mapped = map_tbl[m_st[w]];
`ifdef CHOP_ANIM_EN
         if (m_phase && m_st[w] == 1) mapped = 0;
`endif
         e.sel   = mapped * 4 + m_dir[w];
         e.addr  = (v - m_y[w]) * WIDTH + (h - m_x[w]);
         e.owner = w + 1;
         e.hit   = 1'b1;
      end
      return e;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_x[i] <= 0; m_y[i] <= 0; m_dir[i] <= 0; m_st[i] <= 0;
         end
         m_vs_prev <= 1'b0;
         m_cnt     <= 0;
         m_phase   <= 1'b0;
         m_e1      <= '{0, 0, 0, 1'b0};
         m_o2      <= 0;
         m_v2      <= 0;
         m_p2      <= 0;
      end else begin
         m_e1      <= model_pix(int'(hcount), int'(vcount));
         m_o2      <= m_e1.owner;
         m_v2      <= (m_e1.hit && rom_data != 0) ? 1 : 0;
         m_p2      <= (m_e1.hit && rom_data != 0) ? int'(rom_data) : 0;
         m_vs_prev <= vsync;
         if (vsync && !m_vs_prev) begin
            m_x[0] <= int'(p1_x); m_y[0] <= int'(p1_y); m_dir[0] <= int'(p1_dir); m_st[0] <= int'(p1_state);
            m_x[1] <= int'(p2_x); m_y[1] <= int'(p2_y); m_dir[1] <= int'(p2_dir); m_st[1] <= int'(p2_state);
            if (m_cnt == ANIM_FRAMES - 1) begin
               m_cnt   <= 0;
               m_phase <= !m_phase;
            end else begin
               m_cnt <= m_cnt + 1;
            end
         end
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic cmp(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cmp_all();
      cmp("sprite_sel", int'(sprite_sel), m_e1.sel);
      cmp("pix_addr",   int'(pix_addr),   m_e1.addr);
      cmp("owner",      int'(owner),      m_o2);
      cmp("pal_valid",  int'(pal_valid),  m_v2);
      cmp("pal_index",  int'(pal_index),  m_p2);
   endtask

   task automatic step(input int h, input int v, input bit vs, input int rom);
      hcount   = 11'(h);
      vcount   = 10'(v);
      vsync    = vs;
      rom_data = 8'(rom);
      @(posedge clk);
      @(negedge clk);
      cmp_all();
   endtask

   task automatic set_players(input int x1, input int y1, input int d1, input int s1,
                              input int x2, input int y2, input int d2, input int s2);
      p1_x = 11'(x1); p1_y = 10'(y1); p1_dir = 2'(d1); p1_state = 4'(s1);
      p2_x = 11'(x2); p2_y = 10'(y2); p2_dir = 2'(d2); p2_state = 4'(s2);
   endtask

   task automatic vsync_pulse();
      step(1000, 700, 1'b1, 0);
      step(1000, 700, 1'b0, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      set_players(0, 0, 0, 0, 0, 0, 0, 0);
      hcount = '0; vcount = '0; vsync = 1'b0; rom_data = '0;
      @(negedge clk);
      step(1000, 700, 1'b0, 5);
      step(1000, 700, 1'b0, 5);
      cmp("reset_sel", int'(sprite_sel), 0);
      cmp("reset_owner", int'(owner), 0);
      cmp("reset_valid", int'(pal_valid), 0);
      rst_n = 1'b1;

      // Single player, first pixel of sprite.
      set_players(100, 50, 3, 0, 500, 400, 1, 2);
      vsync_pulse();
      step(100, 50, 1'b0, 0);
      cmp("p1_sel", int'(sprite_sel), 3);
      cmp("p1_addr", int'(pix_addr), 0);
      step(101, 50, 1'b0, 8'h2A);
      cmp("p1_owner", int'(owner), 1);
      cmp("p1_valid", int'(pal_valid), 1);
      cmp("p1_index", int'(pal_index), 8'h2A);
      step(1000, 700, 1'b0, 0);

      // Overlap: lower player wins, then tie goes to P1.
      set_players(100, 50, 3, 0, 110, 60, 1, 2);
      vsync_pulse();
      step(115, 65, 1'b0, 0);
      cmp("ovl_addr", int'(pix_addr), 165);
      cmp("ovl_sel", int'(sprite_sel), 9);
      step(1000, 700, 1'b0, 7);
      cmp("ovl_owner", int'(owner), 2);
      set_players(100, 50, 3, 0, 110, 50, 1, 2);
      vsync_pulse();
      step(115, 65, 1'b0, 0);
      cmp("tie_addr", int'(pix_addr), 495);
      step(1000, 700, 1'b0, 7);
      cmp("tie_owner", int'(owner), 1);

      // Mid-frame move is ignored until the next vsync edge.
      p1_x = 11'd300;
      step(100, 50, 1'b0, 0);
      step(300, 50, 1'b0, 9);
      cmp("tear_old_owner", int'(owner), 1);
      step(1000, 700, 1'b0, 9);
      cmp("tear_new_owner", int'(owner), 0);
      step(1000, 700, 1'b1, 0);
      p1_x = 11'd700;
      step(1000, 700, 1'b1, 0);
      p1_x = 11'd300;
      step(1000, 700, 1'b0, 0);
      step(100, 50, 1'b0, 0);
      cmp("moved_old_addr", int'(pix_addr), 0);
      step(300, 50, 1'b0, 4);
      cmp("moved_old_owner", int'(owner), 0);
      step(1000, 700, 1'b0, 4);
      cmp("moved_new_owner", int'(owner), 1);

      // State/direction mapping.
      set_players(300, 50, 1, 6, 500, 400, 1, 2);
      vsync_pulse();
      step(300, 50, 1'b0, 0);
      cmp("map_6_1", int'(sprite_sel), 21);
      set_players(300, 50, 2, 10, 500, 400, 1, 2);
      vsync_pulse();
      step(300, 50, 1'b0, 0);
      cmp("map_10_2", int'(sprite_sel), 38);
      set_players(300, 50, 0, 13, 500, 400, 1, 2);
      vsync_pulse();
      step(300, 50, 1'b0, 0);
      cmp("map_13_0", int'(sprite_sel), 0);

      // Screen-edge players: no wrap in either axis, transparent index.
      set_players(2040, 50, 0, 0, 500, 400, 1, 2);
      vsync_pulse();
      step(2047, 50, 1'b0, 0);
      cmp("edge_addr", int'(pix_addr), 7);
      step(0, 50, 1'b0, 8'h11);
      cmp("wrap_addr", int'(pix_addr), 0);
      cmp("edge_index", int'(pal_index), 8'h11);
      step(2040, 51, 1'b0, 3);
      cmp("wrap_owner", int'(owner), 0);
      step(1000, 700, 1'b0, 0);
      cmp("transp_owner", int'(owner), 1);
      cmp("transp_valid", int'(pal_valid), 0);
      cmp("transp_index", int'(pal_index), 0);
      set_players(2040, 1000, 0, 0, 500, 400, 1, 2);
      vsync_pulse();
      step(2047, 1023, 1'b0, 0);
      cmp("vedge_addr", int'(pix_addr), 23 * 32 + 7);

      // Sweep an overlapping region; the model checks every pixel.
      set_players(100, 50, 2, 3, 120, 70, 0, 8);
      vsync_pulse();
      for (int v = 45; v <= 105; v += 6)
         for (int h = 95; h <= 160; h += 3)
            step(h, v, 1'b0, (h * 7 + v) & 8'hFF);

      // Asynchronous reset in the middle of a sweep.
      step(130, 80, 1'b0, 0);
      hcount = 11'd131;
      rom_data = 8'h55;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      cmp("arst_sel", int'(sprite_sel), 0);
      cmp("arst_addr", int'(pix_addr), 0);
      cmp("arst_owner", int'(owner), 0);
      cmp("arst_valid", int'(pal_valid), 0);
      cmp("arst_index", int'(pal_index), 0);
      @(negedge clk);
      cmp_all();
      rst_n = 1'b1;
      step(1000, 700, 1'b0, 0);

      // Chop sprite per latched frame: phase toggles every ANIM_FRAMES vsyncs.
      set_players(300, 50, 0, 1, 500, 400, 1, 2);
      for (int k = 0; k < 4; k++) begin
         vsync_pulse();
         step(300, 50, 1'b0, 0);
`ifdef CHOP_ANIM_EN
         cmp("chop_sel", int'(sprite_sel), (k == 0 || k == 3) ? 4 : 0);
`else
         cmp("chop_sel", int'(sprite_sel), 4);
`endif
      end
      step(1000, 700, 1'b0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
